disp_scan_mux: RTL and testbench
================================

Name: disp_scan_mux

Overview:
- Parametrised successor to the fixed 16-to-4 nibble selector with external select.
- Owns its own digit scan counter and prescaler, so no separate select-counter block is needed.
- Frame-synchronous load path for coherent display updates, per-digit blanking mask, and anode guard time.
- Sits between the keyboard-decode/data registers and the multiplexed 7-segment decoder and anode drivers.

Parameters:
DIGITS, 4, number of multiplexed digits (>=2)
W, 4, bits per digit
PRESCALE, 50000, clk cycles per digit slot (>=2)
GUARD, 1, cycles at start of each slot with all anodes off (0 <= GUARD < PRESCALE)
SYNC_LOAD, 1, 1 = load applied at frame boundary; 0 = applied next cycle
SW, $clog2(DIGITS), select width (derived, localparam)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
i  in  DIGITS*W  digit data; digit k = i[k*W+W-1:k*W]
dm  in  DIGITS  digit enable mask, 1 = digit shown
ld  in  1  load strobe, samples i and dm
y  out  W  data of currently scanned digit
s  out  SW  index of currently scanned digit
an  out  DIGITS  anode enables, active-low one-hot
frame  out  1  one-cycle pulse on scan wrap
pend  out  1  load captured, not yet applied

Behaviour:
- Single clock domain. Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk.
- Reset values: pc=0, s=0, shadow data=0, shadow mask=0, pending regs=0, pend=0, frame=0. Consequently y=0 and an=all ones (everything dark).
- Prescaler pc counts 0..PRESCALE-1, then wraps to 0.
- When pc==PRESCALE-1: s increments. s==DIGITS-1 wraps to 0.
- frame is registered. It is 1 for exactly the cycle after s wraps DIGITS-1 -> 0, i.e. the first cycle of digit 0.
- y = shadow data slice at s. Combinational from registers, zero added latency.
- an[k]=0 only when all of these hold: k==s, pc>=GUARD, shadow mask[k]=1. Otherwise an[k]=1.
- GUARD=0 means no dead time. Masked digits still consume their slot; they are never skipped.
- SYNC_LOAD=1:
  - ld=1 captures i and dm into pending regs and sets pend=1.
  - At frame end (s==DIGITS-1 and pc==PRESCALE-1) with pend=1: shadow <= pending, pend <= 0.
  - ld on the frame-end cycle itself: new i/dm go directly to shadow that edge, bypassing pending; pend <= 0.
  - ld while pend=1: overwrites pending, last write wins; pend stays 1.
- SYNC_LOAD=0: ld=1 loads shadow at the next edge; pend is tied 0.
- Reset asserted mid-slot or mid-pending: all state returns to reset values; the pending load is discarded.
- No handshake back-pressure. ld is accepted every cycle.

Decomposition:
- Shared package disp_pkg:
  - function clog2 (if toolchain lacks $clog2)
  - localparam DEFAULT_PRESCALE = 50000
  - anode polarity constant AN_ON = 1'b0
- One sub-module is natural: scan_timer, which holds pc and s and produces the slot-advance and frame-end strobes. It is parametrised by DIGITS and PRESCALE and is reusable for keyboard column scanning.
- The mux, shadow/pending registers and anode decode live in the top.

Test Plan:
All scenarios use DIGITS=4, W=4, PRESCALE=4, GUARD=1, SYNC_LOAD=1 unless stated.
1. Reset: hold rst_n=0 for 3 cycles with ld=1, i=16'hABCD -> y=0, s=0, an=4'b1111, pend=0, frame=0. After release, s advances every 4 cycles: 0,1,2,3,0.
2. Load and scan: ld=1 at s=1, i=16'h4321, dm=4'hF -> pend=1 until frame end, then shadow updates. Next frame shows y=1,2,3,4 for s=0..3. an is 1111 on pc=0 of each slot, then 1110, 1101, 1011, 0111 on pc=1..3.
3. Frame-end collision: ld at s=3, pc=3 with i=16'h9876 -> pend stays 0; next cycle frame=1, s=0, y=6.
4. Last-wins: ld i=16'h1111 then ld i=16'h2222 three cycles later, same frame -> next frame shows all digits =2.
5. Blanking: dm=4'b0101 -> an never drives digits 1 or 3 low. s still spends 4 cycles on each of those slots.
6. Reset mid-pending: ld i=16'h5555, then rst_n=0 before frame end -> pend=0, shadow=0. After release, y=0 and an=1111 for the whole next frame.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the display scan multiplexer and its scan timer.
package disp_pkg;

    localparam int DEFAULT_PRESCALE = 50000;

    // Anode drivers are active-low.
    localparam logic AN_ON = 1'b0;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/disp_scan_mux_scan_timer.sv
// Prescaler plus slot index counter; reusable for any row/column scanning job.
module scan_timer
    import disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = DEFAULT_PRESCALE,
    localparam int SW      = clog2(DIGITS),
    localparam int PCW     = clog2(PRESCALE)
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [PCW-1:0] o_pc,
    output logic [SW-1:0]  o_s,
    output logic           o_slot_adv,
    output logic           o_frame_end
);

    localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);
    localparam logic [SW-1:0]  S_LAST  = SW'(DIGITS - 1);

    logic [PCW-1:0] r_pc;
    logic [SW-1:0]  r_s;
    logic           w_slot_adv;

    assign w_slot_adv  = (r_pc == PC_LAST);
    assign o_slot_adv  = w_slot_adv;
    assign o_frame_end = w_slot_adv && (r_s == S_LAST);
    assign o_pc        = r_pc;
    assign o_s         = r_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_s  <= '0;
        end else if (w_slot_adv) begin
            r_pc <= '0;
            r_s  <= (r_s == S_LAST) ? '0 : r_s + 1'b1;
        end else begin
            r_pc <= r_pc + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan_mux.sv
// Multiplexed display scanner: owns its scan timing, double-buffers digit data/mask
// so updates land on a frame boundary, and blanks anodes for GUARD cycles per slot.
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int W         = 4,
    parameter int PRESCALE  = DEFAULT_PRESCALE,
    parameter int GUARD     = 1,
    parameter int SYNC_LOAD = 1,
    localparam int SW       = clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS*W-1:0]   i,
    input  logic [DIGITS-1:0]     dm,
    input  logic                  ld,
    output logic [W-1:0]          y,
    output logic [SW-1:0]         s,
    output logic [DIGITS-1:0]     an,
    output logic                  frame,
    output logic                  pend
);

    localparam int PCW = clog2(PRESCALE);
    localparam logic [SW-1:0] S_LAST = SW'(DIGITS - 1);

    logic [PCW-1:0]      w_pc;
    logic [SW-1:0]       w_s;
    logic                w_slot_adv;
    logic                w_frame_end;
    logic                w_guard_ok;

    logic [DIGITS*W-1:0] r_shadow_d;
    logic [DIGITS-1:0]   r_shadow_m;
    logic                r_frame;

    scan_timer #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) u_scan_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_pc        (w_pc),
        .o_s         (w_s),
        .o_slot_adv  (w_slot_adv),
        .o_frame_end (w_frame_end)
    );

    if (GUARD == 0) begin : g_no_guard
        assign w_guard_ok = 1'b1;
    end else begin : g_guard
        assign w_guard_ok = (w_pc >= PCW'(GUARD));
    end

    if (SYNC_LOAD != 0) begin : g_sync_load
        logic [DIGITS*W-1:0] r_pend_d;
        logic [DIGITS-1:0]   r_pend_m;
        logic                r_pend;

        // A load arriving on the frame-end cycle is newer than anything pending,
        // so it goes straight to the shadow and the pending copy is dropped.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_shadow_d <= '0;
                r_shadow_m <= '0;
                r_pend_d   <= '0;
                r_pend_m   <= '0;
                r_pend     <= 1'b0;
            end else if (w_slot_adv && (w_s == S_LAST)) begin
                if (ld) begin
                    r_shadow_d <= i;
                    r_shadow_m <= dm;
                end else if (r_pend) begin
                    r_shadow_d <= r_pend_d;
                    r_shadow_m <= r_pend_m;
                end
                r_pend <= 1'b0;
            end else if (ld) begin
                r_pend_d <= i;
                r_pend_m <= dm;
                r_pend   <= 1'b1;
            end
        end

        assign pend = r_pend;
    end else begin : g_direct_load
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_shadow_d <= '0;
                r_shadow_m <= '0;
            end else if (ld) begin
                r_shadow_d <= i;
                r_shadow_m <= dm;
            end
        end

        assign pend = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_frame_end;
        end
    end

    always_comb begin
        y  = '0;
        an = {DIGITS{~AN_ON}};
        for (int k = 0; k < DIGITS; k++) begin
            if (w_s == SW'(k)) begin
                y = r_shadow_d[k*W +: W];
                if (w_guard_ok && r_shadow_m[k]) begin
                    an[k] = AN_ON;
                end
            end
        end
    end

    assign s     = w_s;
    assign frame = r_frame;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux at DIGITS=4, W=4, PRESCALE=4, GUARD=1, SYNC_LOAD=1.
module tb_disp_scan_mux;

    localparam int NVEC = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i;
    logic [3:0]  dm;
    logic        ld;
    logic [3:0]  y;
    logic [1:0]  s;
    logic [3:0]  an;
    logic        frame;
    logic        pend;

    typedef struct {
        logic        ld;
        logic [15:0] i;
        logic [3:0]  dm;
        logic [3:0]  y;
        logic [1:0]  s;
        logic [3:0]  an;
        logic        frame;
        logic        pend;
    } vec_t;

    vec_t       tbl [NVEC];
    logic [1:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    disp_scan_mux #(
        .DIGITS    (4),
        .W         (4),
        .PRESCALE  (4),
        .GUARD     (1),
        .SYNC_LOAD (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (i),
        .dm    (dm),
        .ld    (ld),
        .y     (y),
        .s     (s),
        .an    (an),
        .frame (frame),
        .pend  (pend)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_an(input int sl, input int pc, input logic [3:0] mask);
        logic [3:0] r;
        r = 4'hF;
        if (pc >= 1 && mask[sl]) r[sl] = 1'b0;
        return r;
    endfunction

    // Scenario timeline counted in edges since reset release: shadow contents and
    // pending windows are written out by hand from the load events listed below.
    task automatic build_table();
        logic [15:0] data;
        logic [3:0]  mask;
        int          sl;
        int          pc;
        for (int t = 0; t < NVEC; t++) begin
            sl = (t / 4) % 4;
            pc = t % 4;
            if (t < 16)      data = 16'h0000;
            else if (t < 48) data = 16'h4321;
            else if (t < 64) data = 16'h9876;
            else             data = 16'h2222;
            if (t < 16)      mask = 4'h0;
            else if (t < 80) mask = 4'hF;
            else             mask = 4'b0101;
            tbl[t].ld    = 1'b0;
            tbl[t].i     = 16'hDEAD;
            tbl[t].dm    = 4'h0;
            tbl[t].y     = data[sl*4 +: 4];
            tbl[t].s     = 2'(sl);
            tbl[t].an    = exp_an(sl, pc, mask);
            tbl[t].frame = (t % 16 == 0) && (t > 0);
            tbl[t].pend  = (t >= 5 && t <= 15) || (t >= 50 && t <= 63) ||
                           (t >= 66 && t <= 79) || (t >= 98);
        end
        tbl[4]  = '{1'b1, 16'h4321, 4'hF, tbl[4].y,  tbl[4].s,  tbl[4].an,  tbl[4].frame,  tbl[4].pend};
        tbl[47] = '{1'b1, 16'h9876, 4'hF, tbl[47].y, tbl[47].s, tbl[47].an, tbl[47].frame, tbl[47].pend};
        tbl[49] = '{1'b1, 16'h1111, 4'hF, tbl[49].y, tbl[49].s, tbl[49].an, tbl[49].frame, tbl[49].pend};
        tbl[52] = '{1'b1, 16'h2222, 4'hF, tbl[52].y, tbl[52].s, tbl[52].an, tbl[52].frame, tbl[52].pend};
        tbl[65] = '{1'b1, 16'h2222, 4'b0101, tbl[65].y, tbl[65].s, tbl[65].an, tbl[65].frame, tbl[65].pend};
        tbl[97] = '{1'b1, 16'h5555, 4'hF, tbl[97].y, tbl[97].s, tbl[97].an, tbl[97].frame, tbl[97].pend};
    endtask

    initial begin
        rst_n = 1'b0;
        ld    = 1'b1;
        i     = 16'hABCD;
        dm    = 4'hF;
        build_table();

        repeat (3) tick();
        chk("reset_y",     32'(y),     32'h0);
        chk("reset_s",     32'(s),     32'h0);
        chk("reset_an",    32'(an),    32'hF);
        chk("reset_pend",  32'(pend),  32'h0);
        chk("reset_frame", 32'(frame), 32'h0);

        rst_n = 1'b1;
        for (int t = 0; t < NVEC; t++) begin
            ld = tbl[t].ld;
            i  = tbl[t].i;
            dm = tbl[t].dm;
            chk($sformatf("t%0d_y", t),     32'(y),     32'(tbl[t].y));
            chk($sformatf("t%0d_s", t),     32'(s),     32'(tbl[t].s));
            chk($sformatf("t%0d_an", t),    32'(an),    32'(tbl[t].an));
            chk($sformatf("t%0d_frame", t), 32'(frame), 32'(tbl[t].frame));
            chk($sformatf("t%0d_pend", t),  32'(pend),  32'(tbl[t].pend));
            tick();
        end

        // Reset lands mid-slot with a load still pending; it must be discarded.
        ld    = 1'b0;
        i     = 16'hDEAD;
        dm    = 4'hF;
        rst_n = 1'b0;
        tick();
        chk("midrst_pend",  32'(pend),  32'h0);
        chk("midrst_y",     32'(y),     32'h0);
        chk("midrst_an",    32'(an),    32'hF);
        chk("midrst_s",     32'(s),     32'h0);
        chk("midrst_frame", 32'(frame), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) exp_q.push_back(2'((k / 4) % 4));
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("post_%0d_s", k),     32'(s),     32'(exp_q.pop_front()));
            chk($sformatf("post_%0d_y", k),     32'(y),     32'h0);
            chk($sformatf("post_%0d_an", k),    32'(an),    32'hF);
            chk($sformatf("post_%0d_pend", k),  32'(pend),  32'h0);
            chk($sformatf("post_%0d_frame", k), 32'(frame), 32'(k == 16));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
